// File: rtl/nv_nvdla_dmaif_rdrsp_lat_buf.sv
// Read-response latency buffer: credit-protected response FIFO that unpacks
// each stored response into its masked memory atoms, one atom per cycle.
module nv_nvdla_dmaif_rdrsp_lat_buf #(
   parameter int DATA_W = 512,
   parameter int MASK_W = 2,
   parameter int ATOM_W = DATA_W / MASK_W,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rstn,
   input  logic [DATA_W+MASK_W-1:0] dmaif_rd_rsp_pd,
   input  logic                     dmaif_rd_rsp_pvld,
   output logic                     dmaif_rd_rsp_prdy,
   input  logic                     rd_req_issue,
   output logic                     rd_req_credit,
   output logic [CNT_W-1:0]         free_cnt,
   output logic [ATOM_W-1:0]        atom_pd,
   output logic                     atom_pvld,
   input  logic                     atom_prdy,
   output logic                     atom_last,
   output logic                     err_unexp,
   output logic                     err_zero_mask
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
   localparam int PD_W  = DATA_W + MASK_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PD_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_occ;
   logic [CNT_W-1:0]  r_outs;
   logic [IDX_W-1:0]  r_idx;
   logic              r_err_unexp;
   logic              r_err_zero_mask;

   logic              w_acc;
   logic              w_store;
   logic              w_pop;
   logic              w_avld;
   logic [PD_W-1:0]   w_head;
   logic [MASK_W-1:0] w_mask;
   logic [DATA_W-1:0] w_data;
   logic [IDX_W-1:0]  w_sel;
   logic              w_found;
   logic              w_above;
   logic              w_last;
   logic [CNT_W:0]    w_used;

   assign dmaif_rd_rsp_prdy = (r_occ < DEPTH_C);
   assign w_acc   = dmaif_rd_rsp_pvld & dmaif_rd_rsp_prdy;
   assign w_store = w_acc & (|dmaif_rd_rsp_pd[PD_W-1 -: MASK_W]);

   assign w_used        = {1'b0, r_occ} + {1'b0, r_outs};
   assign rd_req_credit = (w_used < {1'b0, DEPTH_C});
   assign free_cnt      = rd_req_credit ? (DEPTH_C - w_used[CNT_W-1:0]) : '0;

   assign w_head = r_mem[r_rptr];
   assign w_mask = w_head[PD_W-1 -: MASK_W];
   assign w_data = w_head[DATA_W-1:0];
   assign w_avld = (r_occ != '0);

   // Skip clear mask bits: pick the lowest set bit at or above the atom index.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_above = 1'b0;
      for (int i = 0; i < MASK_W; i++) begin
         if (!w_found && w_mask[i] && (i >= int'(r_idx))) begin
            w_sel   = IDX_W'(i);
            w_found = 1'b1;
         end
      end
      for (int i = 0; i < MASK_W; i++) begin
         if (w_mask[i] && (i > int'(w_sel))) begin
            w_above = 1'b1;
         end
      end
      w_last = !w_above;
   end

   assign w_pop     = w_avld & atom_prdy & w_last;
   assign atom_pvld = w_avld;
   assign atom_last = w_avld & w_last;
   assign atom_pd   = w_avld ? w_data[w_sel*ATOM_W +: ATOM_W] : '0;
   assign err_unexp     = r_err_unexp;
   assign err_zero_mask = r_err_zero_mask;

   // Storage is deliberately left out of reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (w_store) begin
         r_mem[r_wptr] <= dmaif_rd_rsp_pd;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_occ           <= '0;
         r_outs          <= '0;
         r_idx           <= '0;
         r_err_unexp     <= 1'b0;
         r_err_zero_mask <= 1'b0;
      end else begin
         if (w_store) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
            r_idx  <= '0;
         end else if (w_avld && atom_prdy) begin
            r_idx  <= w_sel + IDX_W'(1);
         end
         case ({w_store, w_pop})
            2'b10:   r_occ <= r_occ + CNT_W'(1);
            2'b01:   r_occ <= r_occ - CNT_W'(1);
            default: ;
         endcase
         // A response with nothing outstanding holds the count at zero.
         case ({rd_req_issue, w_acc})
            2'b10:   if (r_outs < DEPTH_C) r_outs <= r_outs + CNT_W'(1);
            2'b01:   if (r_outs != '0)     r_outs <= r_outs - CNT_W'(1);
            default: ;
         endcase
         if (w_acc && (r_outs == '0)) begin
            r_err_unexp <= 1'b1;
         end
         if (w_acc && !w_store) begin
            r_err_zero_mask <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nv_nvdla_dmaif_rdrsp_lat_buf.sv
// Directed bench for the read-response latency buffer: credits, unpacking,
// backpressure with pointer wrap, accounting corners and async reset.
module tb_nv_nvdla_dmaif_rdrsp_lat_buf;

   logic         clk;
   logic         rstn;
   logic [513:0] rspPd;
   logic         rspPvld;
   logic         rspPrdy;
   logic         reqIssue;
   logic         reqCredit;
   logic [3:0]   freeCnt;
   logic [255:0] atomPd;
   logic         atomPvld;
   logic         atomPrdy;
   logic         atomLast;
   logic         errUnexp;
   logic         errZeroMask;

   int errCount;
   int checkCount;

   nv_nvdla_dmaif_rdrsp_lat_buf dut (
      .nvdla_core_clk    (clk),
      .nvdla_core_rstn   (rstn),
      .dmaif_rd_rsp_pd   (rspPd),
      .dmaif_rd_rsp_pvld (rspPvld),
      .dmaif_rd_rsp_prdy (rspPrdy),
      .rd_req_issue      (reqIssue),
      .rd_req_credit     (reqCredit),
      .free_cnt          (freeCnt),
      .atom_pd           (atomPd),
      .atom_pvld         (atomPvld),
      .atom_prdy         (atomPrdy),
      .atom_last         (atomLast),
      .err_unexp         (errUnexp),
      .err_zero_mask     (errZeroMask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [255:0] actual,
                              input logic [255:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of response/issue, then return the inputs to idle.
   task automatic applyStimulus(input logic vld, input logic [1:0] mask,
                                input logic [255:0] hi, input logic [255:0] lo,
                                input logic issue);
      rspPvld  = vld;
      rspPd    = {mask, hi, lo};
      reqIssue = issue;
      tick();
      rspPvld  = 1'b0;
      reqIssue = 1'b0;
   endtask

   function automatic logic [255:0] fillAtom(input int entry, input int half);
      return 256'(32'h100 + entry * 2 + half);
   endfunction

   initial begin
      int acceptStep;
      logic accepted;
      errCount   = 0;
      checkCount = 0;
      rstn       = 1'b0;
      rspPd      = '0;
      rspPvld    = 1'b0;
      reqIssue   = 1'b0;
      atomPrdy   = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      checkOutput("rst_credit", 256'(reqCredit), 256'd1);
      checkOutput("rst_free", 256'(freeCnt), 256'd8);
      checkOutput("rst_prdy", 256'(rspPrdy), 256'd1);
      checkOutput("rst_pvld", 256'(atomPvld), 256'd0);
      checkOutput("rst_err_unexp", 256'(errUnexp), 256'd0);
      checkOutput("rst_err_zero", 256'(errZeroMask), 256'd0);

      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 2'b00, '0, '0, 1'b1);
         checkOutput($sformatf("issue_free_%0d", k), 256'(freeCnt), 256'(8 - k));
      end
      checkOutput("issue_credit0", 256'(reqCredit), 256'd0);

      atomPrdy = 1'b1;
      applyStimulus(1'b1, 2'b11, 256'hB, 256'hA, 1'b0);
      checkOutput("full_free0", 256'(freeCnt), 256'd0);
      checkOutput("m11_pd0", atomPd, 256'hA);
      checkOutput("m11_last0", 256'(atomLast), 256'd0);
      tick();
      checkOutput("m11_pd1", atomPd, 256'hB);
      checkOutput("m11_last1", 256'(atomLast), 256'd1);
      tick();
      checkOutput("m11_done", 256'(atomPvld), 256'd0);
      checkOutput("m11_free1", 256'(freeCnt), 256'd1);

      applyStimulus(1'b1, 2'b10, 256'hD, 256'hC, 1'b0);
      checkOutput("m10_pvld", 256'(atomPvld), 256'd1);
      checkOutput("m10_pd", atomPd, 256'hD);
      checkOutput("m10_last", 256'(atomLast), 256'd1);
      tick();
      checkOutput("m10_done", 256'(atomPvld), 256'd0);
      checkOutput("m10_free", 256'(freeCnt), 256'd2);

      applyStimulus(1'b1, 2'b00, 256'hF, 256'hE, 1'b0);
      checkOutput("m00_pvld", 256'(atomPvld), 256'd0);
      checkOutput("m00_err", 256'(errZeroMask), 256'd1);
      checkOutput("m00_free", 256'(freeCnt), 256'd3);

      atomPrdy = 1'b0;
      applyStimulus(1'b1, 2'b01, 256'h0, 256'h77, 1'b1);
      checkOutput("same_cyc_free", 256'(freeCnt), 256'd2);
      checkOutput("same_cyc_pd", atomPd, 256'h77);
      atomPrdy = 1'b1;
      tick();
      checkOutput("same_cyc_pop_free", 256'(freeCnt), 256'd3);

      // Fresh start so nothing is outstanding for the unexpected response.
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      applyStimulus(1'b1, 2'b01, 256'h0, 256'h55, 1'b0);
      checkOutput("unexp_err", 256'(errUnexp), 256'd1);
      checkOutput("unexp_pvld", 256'(atomPvld), 256'd1);
      checkOutput("unexp_pd", atomPd, 256'h55);
      checkOutput("unexp_free", 256'(freeCnt), 256'd7);
      tick();
      checkOutput("unexp_done", 256'(atomPvld), 256'd0);

      atomPrdy = 1'b0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 2'b11, fillAtom(k, 1), fillAtom(k, 0), 1'b0);
      end
      checkOutput("full_prdy", 256'(rspPrdy), 256'd0);
      checkOutput("full_hold_pd", atomPd, fillAtom(0, 0));
      rspPvld = 1'b1;
      rspPd   = {2'b11, fillAtom(8, 1), fillAtom(8, 0)};
      tick();
      checkOutput("full_hold_pd2", atomPd, fillAtom(0, 0));
      checkOutput("full_hold_last", 256'(atomLast), 256'd0);

      atomPrdy   = 1'b1;
      acceptStep = -1;
      for (int j = 0; j < 18; j++) begin
         checkOutput($sformatf("drain_pvld_%0d", j), 256'(atomPvld), 256'd1);
         checkOutput($sformatf("drain_pd_%0d", j), atomPd, fillAtom(j / 2, j % 2));
         checkOutput($sformatf("drain_last_%0d", j), 256'(atomLast), 256'(j % 2));
         accepted = rspPvld & rspPrdy;
         tick();
         if (accepted) begin
            rspPvld    = 1'b0;
            acceptStep = j;
         end
      end
      checkOutput("ninth_accept_step", 256'(acceptStep), 256'd2);
      checkOutput("drain_done", 256'(atomPvld), 256'd0);
      checkOutput("drain_free", 256'(freeCnt), 256'd8);

      atomPrdy = 1'b0;
      applyStimulus(1'b1, 2'b11, 256'h2, 256'h1, 1'b0);
      checkOutput("mid_pvld", 256'(atomPvld), 256'd1);
      rstn = 1'b0;
      #2;
      checkOutput("async_rst_pvld", 256'(atomPvld), 256'd0);
      checkOutput("async_rst_free", 256'(freeCnt), 256'd8);
      checkOutput("async_rst_err", 256'(errUnexp), 256'd0);
      tick();
      rstn = 1'b1;
      tick();
      checkOutput("post_rst_pvld", 256'(atomPvld), 256'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
